// File: rtl/hex_dump_pkg.sv
// Shared types, character constants and helpers for the hex-dump character stream.
// HEX_DUMP_ASCII_COL_EN adds the line-end ASCII column states.
package hex_dump_pkg;

    typedef enum logic [3:0] {
        WAIT,
        ADDR,
        COLON,
        SP0,
        HI,
        LO,
        SP1,
`ifdef HEX_DUMP_ASCII_COL_EN
        PAD,
        ASEP,
        ASCII,
        ABAR,
`endif
        CR,
        LF
    } hex_state_t;

    localparam logic [7:0] CHAR_CR    = 8'd13;
    localparam logic [7:0] CHAR_LF    = 8'd10;
    localparam logic [7:0] CHAR_SP    = 8'h20;
    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_BAR   = 8'h7C;
    localparam logic [7:0] CHAR_DOT   = 8'h2E;

    // Uppercase hex digit for one nibble
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    // True for characters the console can show verbatim
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/hex_dump_linebuf.sv
// 16x8 register file holding the bytes of the current text line for the ASCII column.
module hex_dump_linebuf
    import hex_dump_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [16];

    // Store each accepted byte at its column position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hex_dump_stream.sv
// Turns a byte stream into hex-dump text lines ("AAAA: HH HH ... CR LF") one character
// per cycle. The console sink cannot stall, so the byte source is throttled with in_ready.
// Defining HEX_DUMP_ASCII_COL_EN appends padding and a "|....|" ASCII column at line end.
module hex_dump_stream
    import hex_dump_pkg::*;
#(
    parameter int BYTES_PER_LINE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_clr,
    output logic       wreq,
    output logic [7:0] wchar,
    output logic       busy
);

    localparam logic [4:0] BPL = 5'(BYTES_PER_LINE);

    hex_state_t  state;
    logic [15:0] offset;
    logic [15:0] addr_reg;
    logic [4:0]  col;
    logic [3:0]  idx;
    logic [7:0]  data_reg;
    logic        last_reg;

    logic [15:0] eff_offset;
    logic [4:0]  eff_col;
    logic [4:0]  col_inc;
    logic        line_end;
    logic [3:0]  addr_nib;

    // A clear in WAIT takes effect before a byte offered in the same cycle
    assign eff_offset = in_clr ? 16'h0000 : offset;
    assign eff_col    = in_clr ? 5'd0 : col;
    assign col_inc    = col + 5'd1;
    assign line_end   = (col_inc == BPL) || last_reg;
    assign in_ready   = (state == WAIT);
    assign busy       = (state != WAIT);

    // Next offset nibble to print while walking the four ADDR characters
    always_comb begin
        addr_nib = addr_reg[3:0];
        case (idx)
            4'd0:    addr_nib = addr_reg[11:8];
            4'd1:    addr_nib = addr_reg[7:4];
            default: addr_nib = addr_reg[3:0];
        endcase
    end

`ifdef HEX_DUMP_ASCII_COL_EN
    logic [5:0] pad_cnt;
    logic [5:0] pad_init;
    logic [4:0] missing;
    logic [3:0] raddr;
    logic [7:0] rdata;
    logic [7:0] ascii_char;

    assign missing    = BPL - col_inc;
    assign pad_init   = ({1'b0, missing} << 1) + {1'b0, missing} - 6'd1;
    assign raddr      = (state == ASCII) ? idx + 4'd1 : 4'd0;
    assign ascii_char = is_printable(rdata) ? rdata : CHAR_DOT;

    hex_dump_linebuf u_linebuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (in_ready && in_valid),
        .waddr (eff_col[3:0]),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata)
    );
`endif

    // Character sequencer: state names the character currently presented on wchar
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT;
            offset   <= 16'h0000;
            addr_reg <= 16'h0000;
            col      <= 5'd0;
            idx      <= 4'd0;
            data_reg <= 8'h00;
            last_reg <= 1'b0;
            wreq     <= 1'b0;
            wchar    <= 8'h00;
`ifdef HEX_DUMP_ASCII_COL_EN
            pad_cnt  <= 6'd0;
`endif
        end else begin
            case (state)
                WAIT: begin
                    if (in_clr) begin
                        offset <= 16'h0000;
                        col    <= 5'd0;
                    end
                    if (in_valid) begin
                        data_reg <= in_data;
                        last_reg <= in_last;
                        offset   <= eff_offset + 16'd1;
                        wreq     <= 1'b1;
                        if (eff_col == 5'd0) begin
                            addr_reg <= eff_offset;
                            idx      <= 4'd0;
                            state    <= ADDR;
                            wchar    <= nibble_to_ascii(eff_offset[15:12]);
                        end else begin
                            state <= HI;
                            wchar <= nibble_to_ascii(in_data[7:4]);
                        end
                    end
                end
                ADDR: begin
                    if (idx == 4'd3) begin
                        state <= COLON;
                        wchar <= CHAR_COLON;
                    end else begin
                        idx   <= idx + 4'd1;
                        wchar <= nibble_to_ascii(addr_nib);
                    end
                end
                COLON: begin
                    state <= SP0;
                    wchar <= CHAR_SP;
                end
                SP0: begin
                    state <= HI;
                    wchar <= nibble_to_ascii(data_reg[7:4]);
                end
                HI: begin
                    state <= LO;
                    wchar <= nibble_to_ascii(data_reg[3:0]);
                end
                LO: begin
                    state <= SP1;
                    wchar <= CHAR_SP;
                end
                SP1: begin
                    col <= col_inc;
                    if (line_end) begin
`ifdef HEX_DUMP_ASCII_COL_EN
                        wchar <= CHAR_SP;
                        idx   <= 4'd0;
                        if (col_inc != BPL) begin
                            state   <= PAD;
                            pad_cnt <= pad_init;
                        end else begin
                            state <= ASEP;
                        end
`else
                        state <= CR;
                        wchar <= CHAR_CR;
`endif
                    end else begin
                        state <= WAIT;
                        wreq  <= 1'b0;
                        wchar <= 8'h00;
                    end
                end
`ifdef HEX_DUMP_ASCII_COL_EN
                PAD: begin
                    wchar <= CHAR_SP;
                    if (pad_cnt == 6'd0) begin
                        state <= ASEP;
                        idx   <= 4'd0;
                    end else begin
                        pad_cnt <= pad_cnt - 6'd1;
                    end
                end
                ASEP: begin
                    if (idx == 4'd0) begin
                        idx   <= 4'd1;
                        wchar <= CHAR_BAR;
                    end else begin
                        state <= ASCII;
                        idx   <= 4'd0;
                        wchar <= ascii_char;
                    end
                end
                ASCII: begin
                    if (({1'b0, idx} + 5'd1) == col) begin
                        state <= ABAR;
                        wchar <= CHAR_BAR;
                    end else begin
                        idx   <= idx + 4'd1;
                        wchar <= ascii_char;
                    end
                end
                ABAR: begin
                    state <= CR;
                    wchar <= CHAR_CR;
                end
`endif
                CR: begin
                    state <= LF;
                    wchar <= CHAR_LF;
                    col   <= 5'd0;
                end
                LF: begin
                    state <= WAIT;
                    wreq  <= 1'b0;
                    wchar <= 8'h00;
                end
                default: begin
                    state <= WAIT;
                    wreq  <= 1'b0;
                    wchar <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_dump_stream.sv
// Self-checking bench for hex_dump_stream: directed scenarios plus random bytes,
// compared character by character against a text-level model of the dump format.
// Honours HEX_DUMP_ASCII_COL_EN in the same way as the design.
module tb_hex_dump_stream;

    localparam int BPL = 16;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_clr;
    logic       wreq;
    logic [7:0] wchar;
    logic       busy;

    int errors;
    int checks;
    int line_total;

    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    byte unsigned m_line[$];
    int           m_offset;

    hex_dump_stream #(.BYTES_PER_LINE(BPL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_clr   (in_clr),
        .wreq     (wreq),
        .wchar    (wchar),
        .busy     (busy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic byte unsigned hexch(input int n);
        return (n < 10) ? byte'(48 + n) : byte'(55 + n);
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Text-level model: builds the exact characters one accepted byte must produce
    task automatic model_accept(input byte unsigned d, input bit last, input bit clr);
        exp_q.delete();
        if (clr) begin
            m_offset = 0;
            m_line.delete();
        end
        if (m_line.size() == 0) begin
            for (int sh = 12; sh >= 0; sh -= 4) exp_q.push_back(hexch((m_offset >> sh) & 15));
            push_str(": ");
        end
        exp_q.push_back(hexch(d / 16));
        exp_q.push_back(hexch(d % 16));
        push_str(" ");
        m_line.push_back(d);
        if (m_line.size() == BPL || last) begin
`ifdef HEX_DUMP_ASCII_COL_EN
            for (int i = 0; i < 3 * (BPL - m_line.size()); i++) push_str(" ");
            push_str(" |");
            foreach (m_line[i]) exp_q.push_back((m_line[i] >= 32 && m_line[i] <= 126) ? m_line[i] : 8'h2E);
            push_str("|");
`endif
            exp_q.push_back(8'd13);
            exp_q.push_back(8'd10);
            m_line.delete();
        end
        m_offset = (m_offset + 1) % 65536;
    endtask

    // Samples every character pulse after an accept and checks ready/busy around it
    task automatic collect(input string tag);
        bit ready_seen;
        bit busy_lost;
        ready_seen = 1'b0;
        busy_lost  = 1'b0;
        got_q.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wreq !== 1'b1) break;
            got_q.push_back(wchar);
            if (in_ready !== 1'b0) ready_seen = 1'b1;
            if (busy !== 1'b1) busy_lost = 1'b1;
        end
        checkOutput({tag, " ready_during_emit"}, 32'(ready_seen), 32'd0);
        checkOutput({tag, " busy_during_emit"}, 32'(busy_lost), 32'd0);
        checkOutput({tag, " ready_after"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " busy_after"}, 32'(busy), 32'd0);
        checkOutput({tag, " char_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            checkOutput($sformatf("%s char%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        line_total += got_q.size();
    endtask

    // Offers one byte for exactly one cycle, then checks the resulting characters
    task automatic applyStimulus(input string tag, input byte unsigned d, input bit last, input bit clr);
        checkOutput({tag, " ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_clr   = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_clr   = 1'b0;
        model_accept(d, last, clr);
        collect(tag);
    endtask

    task automatic clear_only();
        in_clr = 1'b1;
        @(posedge clk);
        #1;
        in_clr = 1'b0;
        m_offset = 0;
        m_line.delete();
        @(negedge clk);
        checkOutput("clr_only no_wreq", 32'(wreq), 32'd0);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        line_total = 0;
        m_offset   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        in_clr     = 1'b0;

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset wreq", 32'(wreq), 32'd0);
        checkOutput("reset wchar", 32'(wchar), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] full line 00..0F");
        line_total = 0;
        for (int i = 0; i < 16; i++) applyStimulus("full_line", byte'(i), 1'b0, 1'b0);
`ifdef HEX_DUMP_ASCII_COL_EN
        checkOutput("full_line total", line_total, 32'd75);
`else
        checkOutput("full_line total", line_total, 32'd56);
`endif

        $display("[TB] single byte with in_last");
        clear_only();
        line_total = 0;
        applyStimulus("single_last", 8'h41, 1'b1, 1'b0);
`ifdef HEX_DUMP_ASCII_COL_EN
        checkOutput("single_last total", line_total, 32'd60);
`else
        checkOutput("single_last total", line_total, 32'd11);
`endif
        applyStimulus("next_offset", 8'h00, 1'b1, 1'b0);

        $display("[TB] seventeen 0xFF bytes");
        for (int i = 0; i < 17; i++) applyStimulus("ff_run", 8'hFF, 1'b0, 1'b0);
        applyStimulus("ff_close", 8'hFF, 1'b1, 1'b0);

        $display("[TB] clear with byte after 0x20 bytes");
        for (int i = 0; i < 32; i++) applyStimulus("pre_clr", byte'($urandom), 1'b0, 1'b0);
        applyStimulus("clr_5a", 8'h5A, 1'b0, 1'b1);
        checkOutput("clr_5a first_char", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'h30);

        $display("[TB] short line with unprintables");
        clear_only();
        line_total = 0;
        applyStimulus("short_a", 8'h41, 1'b0, 1'b0);
        applyStimulus("short_b", 8'h0A, 1'b0, 1'b0);
        applyStimulus("short_c", 8'h7F, 1'b1, 1'b0);
`ifdef HEX_DUMP_ASCII_COL_EN
        checkOutput("short total", line_total, 32'd62);
`else
        checkOutput("short total", line_total, 32'd17);
`endif

        $display("[TB] reset mid-line");
        applyStimulus("pre_rst", 8'h12, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h34;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst wreq", 32'(wreq), 32'd0);
        checkOutput("midrst wchar", 32'(wchar), 32'd0);
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst hold wreq", 32'(wreq), 32'd0);
        rst_n = 1'b1;
        m_offset = 0;
        m_line.delete();
        @(negedge clk);
        applyStimulus("post_rst", 8'h33, 1'b0, 1'b0);

        $display("[TB] random bytes");
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 15) == 0)
                clear_only();
            else
                applyStimulus("random", byte'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_dump_stream.md
# hex_dump_stream

Character-stream producer that turns a raw byte stream into hex-dump text lines for the on-screen text console. It sits between the SD-card file reader (byte source) and the character-stream console writer (wreq/wchar sink). Each line carries an offset prefix, per-byte hex fields and CR/LF, and optionally an ASCII column. The sink has no backpressure, so this block throttles the byte source instead.

## Interface
- BYTES_PER_LINE, 16, bytes per text line, legal range 1..16
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  source byte valid
- in_ready  out  1  block accepts a byte this cycle
- in_data  in  8  source byte
- in_last  in  1  qualifies in_valid; final byte of file, so close the line after it
- in_clr  in  1  synchronous clear of offset counter and column
- wreq  out  1  one-cycle character strobe to the console writer
- wchar  out  8  ASCII character, valid with wreq
- busy  out  1  high whenever state is not WAIT

## Operation
- Byte accepted when in_valid & in_ready. in_ready = (state==WAIT).
- Line text: "AAAA: " then "HH " per byte, then CR (13) and LF (10).
  - AAAA is the 16-bit offset of the line's first byte as 4 uppercase hex digits.
- Hex digit encoding: 0–9 → 0x30+n; A–F → 0x41+(n−10).
- Offset counter: 16 bits, +1 per accepted byte, wraps 0xFFFF→0x0000.
- Column counter col: 5 bits, counts bytes in the current line.
- FSM states: WAIT, ADDR (4 chars, MSB nibble first), COLON (':'), SP0 (' '), HI, LO, SP1 (' '), PAD, ASEP, ASCII, ABAR, CR, LF.
- On accept:
  - If col==0, go to ADDR; otherwise go to HI.
  - After SP1, col++.
  - If col==BYTES_PER_LINE or the byte had in_last, go to the line-end path (PAD/ASEP/ASCII/ABAR when enabled), then CR, LF, col=0, WAIT.
  - Otherwise return to WAIT.
- in_last with a full line: normal line end, no extra blank line.
- in_clr:
  - Honoured only in WAIT; ignored elsewhere.
  - If asserted with a valid byte, the clear applies first and the byte is accepted at offset 0x0000, col 0.
- Reset, including mid-line: all state is dropped immediately and no further characters are emitted.
  - Reset values: wreq=0, wchar=8'h00, busy=0, in_ready=1, offset=0, col=0, state=WAIT.

## Timing
- wreq/wchar are registered, one character per cycle, with no gaps inside a byte's sequence.
- Byte accepted in cycle N, emitting k characters: wreq is high in cycles N+1..N+k, wreq=0 in N+k+1, and in_ready=1 no earlier than N+k+1.
- Mid-line byte: k=3. First byte of a line: k=9. Add 2 (CR/LF) on the line-end byte, plus the ASCII-column characters when enabled.
- busy is high from N+1 through N+k.

## Configuration
- HEX_DUMP_ASCII_COL_EN defined:
  - Accepted bytes of the current line are stored in a 16-entry line buffer.
  - At line end the block emits the following, then CR, LF:
    - PAD: 3 spaces per missing byte (BYTES_PER_LINE−col).
    - ASEP: " |".
    - ASCII: one char per stored byte, shown verbatim if in 0x20..0x7E, otherwise '.'.
    - ABAR: "|".
  - Full 16-byte line = 75 chars, which fits the 86-column console.
- HEX_DUMP_ASCII_COL_EN undefined:
  - No line buffer; states PAD/ASEP/ASCII/ABAR are absent.
  - Line end goes directly to CR, LF.

## Structure
- Package hex_dump_pkg holds:
  - the state enum;
  - constants CHAR_CR=8'd13, CHAR_LF=8'd10, CHAR_SP=8'h20, CHAR_COLON=8'h3A, CHAR_BAR=8'h7C, CHAR_DOT=8'h2E;
  - function nibble_to_ascii;
  - function is_printable.
- Sub-module hex_dump_linebuf (16×8 register file, write at col, read by index) is instantiated only under HEX_DUMP_ASCII_COL_EN.

## Test plan
- Reset, then feed bytes 0x00..0x0F (BPL=16, macro off) → exactly 56 wreq pulses spelling "0000: 00 01 02 … 0F " CR LF. in_ready is low during emission.
- Single byte 0x41 with in_last (macro off) → "0000: 41 " CR LF (11 chars). Next byte prints offset "0001: ".
- 17 bytes of 0xFF → line 1 starts "0000: ", line 2 is "0010: FF " with no line end until in_last.
- in_clr with in_valid high, data 0x5A, after 0x20 bytes already sent → line prints "0000: 5A ".
- Macro on, bytes 0x41, 0x0A, 0x7F with in_last → "0000: 41 0A 7F " + 39 spaces + " |A..|" CR LF.
- Assert rst_n low mid-line after the 2nd char → wreq drops at once. After release, outputs are at reset values and the next byte starts "0000: ".
